// File: rtl/uncache_write_buffer_if.sv
// ---------------------------------------------------------------------------
// uncache_write_buffer_if
// Bundles the CPU-side uncached request port and the simplified AXI-style
// bus port of the uncached write buffer.
//
//   cpu_*   : CPU uncached load/store request, load data return, stall.
//   AXI_*   : single-beat address/data/response handshakes to the bus.
//
// Modports:
//   master : the write buffer's view. It masters the AXI bus and serves the
//            CPU request port.
//   slave  : the environment's view (CPU plus bus fabric).
// ---------------------------------------------------------------------------
interface uncache_write_buffer_if #(
   parameter int ADDR_WIDTH = 32
);
   // CPU side
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [3:0]            cpu_byteenable;
   logic                  cpu_read;
   logic                  cpu_write;
   logic [31:0]           cpu_wrdata;
   logic [31:0]           cpu_rddata;
   logic                  cpu_new_ins;
   logic                  cpu_stall;

   // Bus responses
   logic                  AXI_rd_dready;
   logic                  AXI_rd_last;
   logic                  AXI_rd_addr_clear;
   logic [31:0]           AXI_rd_data;
   logic                  AXI_wr_next;
   logic                  AXI_wr_ok;
   logic                  AXI_wr_addr_clear;

   // Bus requests
   logic [ADDR_WIDTH-1:0] AXI_addr;
   logic                  AXI_addr_valid;
   logic                  AXI_we;
   logic [2:0]            AXI_size;
   logic [7:0]            AXI_lens;
   logic                  AXI_rd_rready;
   logic                  AXI_wr_dready;
   logic                  AXI_wr_last;
   logic                  AXI_response_rready;
   logic [31:0]           AXI_wr_data;
   logic [3:0]            AXI_byte_enable;

   modport master (
      input  cpu_addr, cpu_byteenable, cpu_read, cpu_write, cpu_wrdata, cpu_new_ins,
      output cpu_rddata, cpu_stall,
      input  AXI_rd_dready, AXI_rd_last, AXI_rd_addr_clear, AXI_rd_data,
             AXI_wr_next, AXI_wr_ok, AXI_wr_addr_clear,
      output AXI_addr, AXI_addr_valid, AXI_we, AXI_size, AXI_lens,
             AXI_rd_rready, AXI_wr_dready, AXI_wr_last, AXI_response_rready,
             AXI_wr_data, AXI_byte_enable
   );

   modport slave (
      output cpu_addr, cpu_byteenable, cpu_read, cpu_write, cpu_wrdata, cpu_new_ins,
      input  cpu_rddata, cpu_stall,
      output AXI_rd_dready, AXI_rd_last, AXI_rd_addr_clear, AXI_rd_data,
             AXI_wr_next, AXI_wr_ok, AXI_wr_addr_clear,
      input  AXI_addr, AXI_addr_valid, AXI_we, AXI_size, AXI_lens,
             AXI_rd_rready, AXI_wr_dready, AXI_wr_last, AXI_response_rready,
             AXI_wr_data, AXI_byte_enable
   );
endinterface

// File: rtl/uncache_write_buffer.sv
// ---------------------------------------------------------------------------
// uncache_write_buffer
// Posted-store buffer for uncached CPU accesses. Stores are queued in a
// WB_DEPTH-entry FIFO and drained one single-beat bus write at a time;
// loads wait until the FIFO is empty so they never overtake older stores.
//
// Ports:
//   clk       : sole clock, rising edge.
//   rst       : asynchronous, active-low reset.
//   bus       : uncache_write_buffer_if.master (CPU request + bus port).
//   wb_empty  : FIFO empty (registered pointers).
//   wb_full   : FIFO full  (registered pointers).
//
// Configuration macro UNCACHE_POSTED_WR_EN:
//   defined   : a store retires as soon as it is queued.
//   undefined : a store is queued but the CPU stalls until that store's own
//               write response arrives.
// ---------------------------------------------------------------------------
module uncache_write_buffer #(
   parameter int WB_DEPTH   = 4,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   uncache_write_buffer_if.master bus,
   output logic                   wb_empty,
   output logic                   wb_full
);
   localparam int IW = $clog2(WB_DEPTH);
   localparam int PW = IW + 1;

   typedef enum logic [2:0] {
      IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, RDONE
   } state_t;

   state_t state, state_next;

   logic [ADDR_WIDTH-1:0] fifo_addr [WB_DEPTH];
   logic [3:0]            fifo_be   [WB_DEPTH];
   logic [31:0]           fifo_data [WB_DEPTH];

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [IW-1:0] wr_idx, rd_idx;

   logic        acc_done, done_eff;
   logic        is_load, is_store;
   logic        enq, pop, load_cap;
   logic        store_done, store_stall, complete, stall_raw;
   logic [31:0] rddata;

   function automatic logic [2:0] size_of(input logic [3:0] be);
      case (be)
         4'b1111:          size_of = 3'b010;
         4'b0011, 4'b1100: size_of = 3'b001;
         default:          size_of = 3'b000;
      endcase
   endfunction

   assign wr_idx   = wr_ptr[IW-1:0];
   assign rd_idx   = rd_ptr[IW-1:0];
   assign wb_empty = (wr_ptr == rd_ptr);
   assign wb_full  = (wr_idx == rd_idx) && (wr_ptr[IW] != rd_ptr[IW]);

   // A request already served stays served until the CPU flags a new one.
   assign done_eff = acc_done & ~bus.cpu_new_ins;
   // Read wins when both are raised; such a request is never queued.
   assign is_load  = bus.cpu_read & ~done_eff;
   assign is_store = bus.cpu_write & ~bus.cpu_read & ~done_eff;

   assign pop      = (state == WRESP) & bus.AXI_wr_ok;
   assign load_cap = (state == RDATA) & bus.AXI_rd_dready & bus.AXI_rd_last;

`ifdef UNCACHE_POSTED_WR_EN
   // A draining pop frees a slot in the same cycle, so a full buffer can
   // still accept the store that is waiting on it.
   assign enq         = is_store & (~wb_full | pop);
   assign store_done  = enq;
   assign store_stall = is_store & ~enq;
`else
   // wr_pend marks that the held store is already queued; it retires on the
   // pop of that entry, which is the only one in the buffer.
   logic wr_pend;

   assign enq         = is_store & ~wr_pend & (~wb_full | pop);
   assign store_done  = is_store & wr_pend & pop;
   assign store_stall = is_store & ~store_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_pend <= 1'b0;
      end else if (store_done) begin
         wr_pend <= 1'b0;
      end else if (enq) begin
         wr_pend <= 1'b1;
      end
   end
`endif

   assign complete  = store_done | (state == RDONE);
   assign stall_raw = is_load ? (state != RDONE) : store_stall;

   assign bus.cpu_stall  = rst & stall_raw;
   assign bus.cpu_rddata = rddata;

   // Control state, pointers and load-return register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         acc_done <= 1'b0;
         rddata   <= '0;
      end else begin
         state <= state_next;
         if (enq) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (complete) begin
            acc_done <= 1'b1;
         end else if (bus.cpu_new_ins) begin
            acc_done <= 1'b0;
         end
         if (load_cap) begin
            rddata <= bus.AXI_rd_data;
         end
      end
   end

   // FIFO storage (data only, not reset)
   always_ff @(posedge clk) begin
      if (enq) begin
         fifo_addr[wr_idx] <= bus.cpu_addr;
         fifo_be[wr_idx]   <= bus.cpu_byteenable;
         fifo_data[wr_idx] <= bus.cpu_wrdata;
      end
   end

   // Bus sequencing: queued stores take priority over a pending load
   always_comb begin
      state_next              = state;
      bus.AXI_addr            = '0;
      bus.AXI_addr_valid      = 1'b0;
      bus.AXI_we              = 1'b0;
      bus.AXI_size            = 3'b000;
      bus.AXI_lens            = 8'h00;
      bus.AXI_rd_rready       = 1'b0;
      bus.AXI_wr_dready       = 1'b0;
      bus.AXI_wr_last         = 1'b0;
      bus.AXI_response_rready = 1'b0;
      bus.AXI_wr_data         = '0;
      bus.AXI_byte_enable     = 4'b0000;

      case (state)
         IDLE: begin
            if (!wb_empty) begin
               state_next = WADDR;
            end else if (is_load) begin
               state_next = RADDR;
            end
         end
         WADDR: begin
            bus.AXI_addr_valid = 1'b1;
            bus.AXI_we         = 1'b1;
            bus.AXI_addr       = fifo_addr[rd_idx];
            bus.AXI_size       = size_of(fifo_be[rd_idx]);
            if (bus.AXI_wr_addr_clear) begin
               state_next = WDATA;
            end
         end
         WDATA: begin
            bus.AXI_wr_dready   = 1'b1;
            bus.AXI_wr_last     = 1'b1;
            bus.AXI_wr_data     = fifo_data[rd_idx];
            bus.AXI_byte_enable = fifo_be[rd_idx];
            if (bus.AXI_wr_next) begin
               state_next = WRESP;
            end
         end
         WRESP: begin
            bus.AXI_response_rready = 1'b1;
            if (bus.AXI_wr_ok) begin
               state_next = IDLE;
            end
         end
         RADDR: begin
            bus.AXI_addr_valid = 1'b1;
            bus.AXI_addr       = bus.cpu_addr;
            bus.AXI_size       = size_of(bus.cpu_byteenable);
            if (bus.AXI_rd_addr_clear) begin
               state_next = RDATA;
            end
         end
         RDATA: begin
            bus.AXI_rd_rready = 1'b1;
            if (load_cap) begin
               state_next = RDONE;
            end
         end
         RDONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end
endmodule
